// File: rtl/cap_grant_arbiter.sv
// -----------------------------------------------------------------------------
// cap_grant_arbiter
//
// Round-robin arbiter for the platform side of the CAP request/grant/release
// channel. One shared capability is granted to one requester at a time. A
// holder that keeps the capability too long while others wait is asked to give
// it back through its release line. Revocation is cooperative only: the grant
// is never withdrawn while the holder still requests.
//
// Build option:
//   CAP_ARB_REVOKE_EN  defined   -> hold counter and REVOKE state are built.
//                      undefined -> s_rel is tied low, C_MAX_HOLD is ignored.
//
// Parameters:
//   C_NUM_REQ   number of requesters (1..16)
//   C_MAX_HOLD  contended-hold budget in cycles; 0 disables revoke
//   C_OWNER_W   width of s_owner (>= clog2(C_NUM_REQ), minimum 1)
//
// Ports:
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   s_req    in   request/hold lines, one per requester
//   s_gnt    out  one-hot-or-zero grant
//   s_rel    out  revoke request to the current holder (subset of s_gnt)
//   s_busy   out  high while a grant is asserted
//   s_owner  out  index of the current holder, 0 when idle
// -----------------------------------------------------------------------------
module cap_grant_arbiter #(
  parameter int C_NUM_REQ  = 4,
  parameter int C_MAX_HOLD = 256,
  parameter int C_OWNER_W  = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [C_NUM_REQ-1:0] s_req,
  output logic [C_NUM_REQ-1:0] s_gnt,
  output logic [C_NUM_REQ-1:0] s_rel,
  output logic                 s_busy,
  output logic [C_OWNER_W-1:0] s_owner
);

  localparam int IDX_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

`ifdef CAP_ARB_REVOKE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_REVOKE, ST_GAP} state_t;
  localparam int CNT_W = (C_MAX_HOLD > 0) ? $clog2(C_MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_MAX_HOLD);
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;
`endif

  state_t                 state_q;
  logic [C_NUM_REQ-1:0]   gnt_q;
  logic                   busy_q;
  logic [C_OWNER_W-1:0]   owner_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       h_q;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [C_NUM_REQ-1:0]   pick_onehot;
  logic [C_NUM_REQ-1:0]   hold_onehot;
  logic                   holder_req;
  logic                   others_req;
  logic [IDX_W-1:0]       ptr_d;

  // (base + off) mod C_NUM_REQ, with base < C_NUM_REQ and off < C_NUM_REQ.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= C_NUM_REQ) sum = sum - C_NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan from ptr upward; iterating from the farthest offset down lets the
  // nearest set bit overwrite earlier candidates.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int o = C_NUM_REQ - 1; o >= 0; o--) begin
      if (s_req[rot_idx(ptr_q, o)]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx(ptr_q, o);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
      assign hold_onehot[gi] = (h_q == IDX_W'(gi));
    end
  endgenerate

  assign holder_req = |(s_req & hold_onehot);
  assign others_req = |(s_req & ~hold_onehot);
  assign ptr_d      = (h_q == IDX_W'(C_NUM_REQ - 1)) ? '0 : h_q + 1'b1;

`ifdef CAP_ARB_REVOKE_EN
  logic [C_NUM_REQ-1:0] rel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 revoke_hit;

  // Count only contended cycles; saturate at the budget.
  always_comb begin
    cnt_d = cnt_q;
    if (others_req && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // A zero budget never revokes even though the counter sits at its maximum.
  assign revoke_hit = (C_MAX_HOLD != 0) && (cnt_d == CNT_MAX);
  assign s_rel      = rel_q;
`else
  assign s_rel      = '0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      h_q     <= '0;
`ifdef CAP_ARB_REVOKE_EN
      rel_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        // GAP arbitrates exactly like IDLE, but with ptr already advanced.
        ST_IDLE, ST_GAP: begin
`ifdef CAP_ARB_REVOKE_EN
          rel_q <= '0;
          cnt_q <= '0;
`endif
          if (pick_valid) begin
            state_q <= ST_GRANT;
            gnt_q   <= pick_onehot;
            busy_q  <= 1'b1;
            owner_q <= C_OWNER_W'(pick_idx);
            h_q     <= pick_idx;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
          end
        end

        ST_GRANT: begin
          if (!holder_req) begin
            // Holder release wins over a budget expiring on the same edge.
            state_q <= ST_GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= ptr_d;
          end else begin
`ifdef CAP_ARB_REVOKE_EN
            cnt_q <= cnt_d;
            if (revoke_hit) begin
              state_q <= ST_REVOKE;
              rel_q   <= gnt_q;
            end
`endif
          end
        end

`ifdef CAP_ARB_REVOKE_EN
        // Keep asking until the holder lets go, whether or not others still wait.
        ST_REVOKE: begin
          if (!holder_req) begin
            state_q <= ST_GAP;
            gnt_q   <= '0;
            rel_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign s_gnt   = gnt_q;
  assign s_busy  = busy_q;
  assign s_owner = owner_q;

endmodule

// File: tb/tb_cap_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cap_grant_arbiter
//
// Directed bench for cap_grant_arbiter (4 requesters, budget of 8 cycles).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Revoke scenarios are built when CAP_ARB_REVOKE_EN is defined; otherwise the
// long-contention no-revoke scenario runs.
// -----------------------------------------------------------------------------
module tb_cap_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] rel;
  logic       busy;
  logic [3:0] owner;

  int total;
  int bad;

  cap_grant_arbiter #(
    .C_NUM_REQ (4),
    .C_MAX_HOLD(8),
    .C_OWNER_W (4)
  ) dut (
    .aclk   (clk),
    .aresetn(rst_n),
    .s_req  (req),
    .s_gnt  (gnt),
    .s_rel  (rel),
    .s_busy (busy),
    .s_owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (rel !== 4'b0000) begin bad++; $display("FAIL reset_rel got=%b want=0000", rel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (owner !== 4'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL first_gnt got=%b want=0100", gnt); end
    total++; if (owner !== 4'd2) begin bad++; $display("FAIL first_owner got=%0d want=2", owner); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", busy); end
    $display("test_reset: idle outputs and first grant gnt=%b owner=%0d", gnt, owner);
    req = 4'b0000;
  endtask

  task automatic test_round_robin;
    logic [3:0] order [5];
    logic [3:0] want;
    order[0] = 4'd0; order[1] = 4'd1; order[2] = 4'd2; order[3] = 4'd3; order[4] = 4'd0;
    do_reset();
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      want = 4'b0001 << order[n];
      total++; if (gnt !== want) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", n, gnt, want); end
      total++; if (owner !== order[n]) begin bad++; $display("FAIL rr_owner[%0d] got=%0d want=%0d", n, owner, order[n]); end
      tick();
      tick();
      total++; if (gnt !== want) begin bad++; $display("FAIL rr_hold[%0d] got=%b want=%b", n, gnt, want); end
      req = 4'b1111 & ~want;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_gap[%0d] got=%b want=0000", n, gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_gap_busy[%0d] got=%b want=0", n, busy); end
      req = 4'b1111;
      tick();
      $display("test_round_robin: grant %0d to requester %0d", n, order[n]);
    end
    req = 4'b0000;
  endtask

  task automatic test_non_holder_toggle;
    do_reset();
    req = 4'b0010;
    tick();
    for (int n = 0; n < 4; n++) begin
      req = (n % 2 == 0) ? 4'b1011 : 4'b0110;
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL toggle_gnt[%0d] got=%b want=0010", n, gnt); end
      total++; if (owner !== 4'd1) begin bad++; $display("FAIL toggle_owner[%0d] got=%0d want=1", n, owner); end
    end
    // Holder 1 leaves; ptr moves to 2, so requester 2 wins over 0 and 3.
    req = 4'b1101;
    tick();
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL toggle_next got=%b want=0100", gnt); end
    $display("test_non_holder_toggle: next grant gnt=%b", gnt);
    req = 4'b0000;
  endtask

`ifdef CAP_ARB_REVOKE_EN
  task automatic test_revoke;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    for (int n = 1; n <= 7; n++) begin
      tick();
      total++; if (rel !== 4'b0000) begin bad++; $display("FAIL revoke_early[%0d] got=%b want=0000", n, rel); end
    end
    tick();
    total++; if (rel !== 4'b0001) begin bad++; $display("FAIL revoke_rel got=%b want=0001", rel); end
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL revoke_gnt got=%b want=0001", gnt); end
    // Waiter withdraws: release request must persist.
    req = 4'b0001;
    tick();
    total++; if (rel !== 4'b0001) begin bad++; $display("FAIL revoke_persist got=%b want=0001", rel); end
    req = 4'b0011;
    tick();
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL revoke_gap_gnt got=%b want=0000", gnt); end
    total++; if (rel !== 4'b0000) begin bad++; $display("FAIL revoke_gap_rel got=%b want=0000", rel); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL revoke_handover got=%b want=0010", gnt); end
    total++; if (owner !== 4'd1) begin bad++; $display("FAIL revoke_owner got=%0d want=1", owner); end
    $display("test_revoke: rel after 8 contended cycles, handover to %0d", owner);
    req = 4'b0000;
  endtask

  task automatic test_expiry_drop;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    for (int n = 1; n <= 7; n++) tick();
    req = 4'b0010;
    tick();
    total++; if (rel !== 4'b0000) begin bad++; $display("FAIL expiry_rel got=%b want=0000", rel); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL expiry_gap got=%b want=0000", gnt); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL expiry_next got=%b want=0010", gnt); end
    total++; if (rel !== 4'b0000) begin bad++; $display("FAIL expiry_rel2 got=%b want=0000", rel); end
    $display("test_expiry_drop: holder left on expiry edge, next gnt=%b", gnt);
    req = 4'b0000;
  endtask
`else
  task automatic test_no_revoke;
    int errs;
    errs = 0;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b1111;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (rel !== 4'b0000 || gnt !== 4'b0001) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL no_revoke_cycles got=%0d bad cycles want=0", errs); end
    total++; if (owner !== 4'd0) begin bad++; $display("FAIL no_revoke_owner got=%0d want=0", owner); end
    $display("test_no_revoke: 1000 contended cycles, holder=%0d rel=%b", owner, rel);
    req = 4'b0000;
  endtask
`endif

  task automatic test_async_reset;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    for (int n = 1; n <= 9; n++) tick();
`ifdef CAP_ARB_REVOKE_EN
    total++; if (rel !== 4'b0001) begin bad++; $display("FAIL areset_pre_rel got=%b want=0001", rel); end
`endif
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL areset_pre_gnt got=%b want=0001", gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL areset_gnt got=%b want=0000", gnt); end
    total++; if (rel !== 4'b0000) begin bad++; $display("FAIL areset_rel got=%b want=0000", rel); end
    total++; if (owner !== 4'd0) begin bad++; $display("FAIL areset_owner got=%0d want=0", owner); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
    req = 4'b1010;
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL areset_after got=%b want=0010", gnt); end
    total++; if (owner !== 4'd1) begin bad++; $display("FAIL areset_after_owner got=%0d want=1", owner); end
    $display("test_async_reset: cleared without clock, regrant gnt=%b", gnt);
    req = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_round_robin();
    test_non_holder_toggle();
`ifdef CAP_ARB_REVOKE_EN
    test_revoke();
    test_expiry_drop();
`else
    test_no_revoke();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
